// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side checker for the 4-bit LFSR pattern generator
//   (x^4+x^3+1, Fibonacci form, next(s) = {s[2:0], s[3]^s[2]}).
//   It acquires lock on the incoming word stream and then predicts each
//   following word, flagging mismatches and counting checked/errored words.
//
// Ports
//   clkslow    in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   clr        in   synchronous clear of err_cnt / chk_cnt (lock unaffected)
//   din_valid  in   din carries a generator word this cycle
//   din        in   received 4-bit LFSR word
//   locked     out  checker is synchronised (this is the FSM state bit)
//   err        out  one-cycle pulse: previous valid word mismatched while locked
//   err_cnt    out  saturating count of mismatched words while locked
//   chk_cnt    out  saturating count of words checked while locked
//   expected   out  predicted value of the next valid word
//
// Handshake: a word is consumed on every rising edge where din_valid=1;
// there is no backpressure. All results appear on the edge that samples
// the word.
module lfsr_checker #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clkslow,
  input  logic             rst,
  input  logic             clr,
  input  logic             din_valid,
  input  logic [3:0]       din,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [3:0]       expected
);

  localparam logic [0:0] ST_SYNC   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);

  // Value of the run/miss counters on the word that completes the run.
  localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
  localparam logic [EW-1:0]    ERR_LAST   = EW'(LOSS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [0:0]    state;
  logic [MW-1:0] match_cnt;
  logic [EW-1:0] consec_err;
  logic          chk_inc;
  logic          err_inc;

  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  // The state register is itself the lock flag, so it is already registered.
  assign locked = (state == ST_LOCKED);

  always_comb begin
    chk_inc = 1'b0;
    err_inc = 1'b0;
    if (din_valid && state == ST_LOCKED) begin
      chk_inc = 1'b1;
      err_inc = (din != expected);
    end
  end

  // Synchronisation / prediction FSM.
  always_ff @(posedge clkslow or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      match_cnt  <= '0;
      consec_err <= '0;
      err        <= 1'b0;
      expected   <= 4'b0000;
    end else begin
      err <= 1'b0;
      if (din_valid) begin
        if (state == ST_SYNC) begin
          if (din == 4'b0000) begin
            // Zero is never a legal generator word: drop the partial run
            // but keep the last prediction.
            match_cnt <= '0;
          end else if (match_cnt != '0 && din == expected) begin
            expected <= lfsr_next(din);
            if (match_cnt == MATCH_LAST) begin
              state      <= ST_LOCKED;
              consec_err <= '0;
              match_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end else begin
            // First word of a run, or a non-matching word: restart from it.
            expected  <= lfsr_next(din);
            match_cnt <= MW'(1);
          end
        end else begin
          // Locked: prediction free-runs so a corrupted word cannot
          // re-seed the sequence.
          expected <= lfsr_next(expected);
          if (din == expected) begin
            consec_err <= '0;
          end else begin
            err <= 1'b1;
            if (consec_err == ERR_LAST) begin
              state      <= ST_SYNC;
              match_cnt  <= '0;
              consec_err <= '0;
            end else begin
              consec_err <= consec_err + 1'b1;
            end
          end
        end
      end
    end
  end

  // Saturating counters; clr takes priority over a same-cycle increment.
  always_ff @(posedge clkslow or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      chk_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
      chk_cnt <= '0;
    end else begin
      if (chk_inc && chk_cnt != CNT_MAX) chk_cnt <= chk_cnt + 1'b1;
      if (err_inc && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
//   Self-checking bench for lfsr_checker. A reference model tracks the
//   generator sequence as a position in a 15-entry table and applies the
//   lock / loss / counting rules with plain integer arithmetic.
module tb_lfsr_checker;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 4;
  localparam int CNT_W    = 5;  // small so saturation is reachable quickly

  logic             clkslow = 1'b0;
  logic             rst;
  logic             clr;
  logic             din_valid;
  logic [3:0]       din;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic [3:0]       expected;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clkslow = ~clkslow;

  lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(CNT_W)) dut (
    .clkslow  (clkslow),
    .rst      (rst),
    .clr      (clr),
    .din_valid(din_valid),
    .din      (din),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .chk_cnt  (chk_cnt),
    .expected (expected)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Generator output order starting from 1111.
  logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                           4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  bit               m_locked;
  bit               m_err;
  logic [3:0]       m_exp;
  logic [CNT_W-1:0] m_err_cnt;
  logic [CNT_W-1:0] m_chk_cnt;
  int               m_run;   // consecutive valid words that followed the sequence
  int               m_prev;  // table position of previous valid word, -1 if none
  int               m_pos;   // table position of the predicted word when locked
  int               m_miss;  // consecutive misses while locked

  function automatic int pos_of(input logic [3:0] w);
    for (int i = 0; i < 15; i++) if (seq[i] == w) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_err = 0; m_exp = 4'h0; m_err_cnt = '0; m_chk_cnt = '0;
    m_run = 0; m_prev = -1; m_pos = 0; m_miss = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [3:0] d, input bit c);
    int p;
    m_err = 0;
    if (v) begin
      if (!m_locked) begin
        p = pos_of(d);
        if (p < 0) begin
          m_run = 0; m_prev = -1;
        end else begin
          if (m_prev >= 0 && p == (m_prev + 1) % 15) m_run++;
          else m_run = 1;
          m_prev = p;
          m_exp = seq[(p + 1) % 15];
          if (m_run == LOCK_CNT) begin
            m_locked = 1; m_miss = 0; m_pos = (p + 1) % 15; m_run = 0; m_prev = -1;
          end
        end
      end else begin
        bit hit;
        hit = (d == seq[m_pos]);
        m_pos = (m_pos + 1) % 15;
        m_exp = seq[m_pos];
        if (m_chk_cnt != '1) m_chk_cnt++;
        if (hit) m_miss = 0;
        else begin
          m_err = 1;
          if (m_err_cnt != '1) m_err_cnt++;
          m_miss++;
          if (m_miss == LOSS_CNT) begin
            m_locked = 0; m_miss = 0; m_run = 0; m_prev = -1;
          end
        end
      end
    end
    if (c) begin m_err_cnt = '0; m_chk_cnt = '0; end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [3:0] d, input bit c);
    @(negedge clkslow);
    din_valid = v; din = d; clr = c;
    @(posedge clkslow);
    #1;
    din_valid = 0; clr = 0;
    model_step(v, d, c);
  endtask

  task automatic apply_reset();
    @(negedge clkslow);
    rst = 1;
    #2;
    rst = 0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1; clr = 0; din_valid = 0; din = 4'h0;
    repeat (2) @(posedge clkslow);
    #1;
    checks++;
    if ({locked, err, err_cnt, chk_cnt, expected} !== {1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}, 4'h0}) begin
      errors++;
      $display("FAIL reset_state: got locked=%b err=%b err_cnt=%0d chk_cnt=%0d exp=%b, want all zero",
               locked, err, err_cnt, chk_cnt, expected);
    end
    @(negedge clkslow);
    rst = 0;
    model_reset();
  endtask

  task automatic test_lock();
    logic [3:0] words [3] = '{4'hF, 4'hE, 4'hC};
    bit seen_err = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, words[i], 0);
      seen_err |= err;
      checks++;
      if ({locked, err, expected, err_cnt, chk_cnt} !== {m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt}) begin
        errors++;
        $display("FAIL lock_step%0d: got l=%b e=%b x=%b ec=%0d cc=%0d want l=%b e=%b x=%b ec=%0d cc=%0d",
                 i, locked, err, expected, err_cnt, chk_cnt, m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt);
      end
    end
    checks++;
    if ({locked, expected, err_cnt, chk_cnt, seen_err} !== {1'b1, 4'b1000, {CNT_W{1'b0}}, {CNT_W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL lock_final: got l=%b x=%b ec=%0d cc=%0d err_seen=%b want 1 1000 0 0 0",
               locked, expected, err_cnt, chk_cnt, seen_err);
    end
  endtask

  task automatic test_clean_run();
    bit seen_err = 0;
    for (int i = 0; i < 13; i++) begin
      step(1, seq[(3 + i) % 15], 0);
      seen_err |= err;
      checks++;
      if ({locked, err, expected, err_cnt, chk_cnt} !== {m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt}) begin
        errors++;
        $display("FAIL clean_step%0d: got l=%b e=%b x=%b ec=%0d cc=%0d want l=%b e=%b x=%b ec=%0d cc=%0d",
                 i, locked, err, expected, err_cnt, chk_cnt, m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt);
      end
    end
    checks++;
    if ({locked, chk_cnt, seen_err} !== {1'b1, CNT_W'(13), 1'b0}) begin
      errors++;
      $display("FAIL clean_final: got l=%b cc=%0d err_seen=%b want 1 13 0", locked, chk_cnt, seen_err);
    end
  endtask

  task automatic test_single_error();
    for (int i = 0; i < 15 && m_exp != 4'b1000; i++) step(1, m_exp, 0);
    step(1, 4'b0101, 0);
    checks++;
    if ({err, err_cnt, locked} !== {1'b1, CNT_W'(1), 1'b1}) begin
      errors++;
      $display("FAIL single_err_pulse: got e=%b ec=%0d l=%b want 1 1 1", err, err_cnt, locked);
    end
    step(1, 4'b0001, 0);
    checks++;
    if ({err, expected, err_cnt} !== {1'b0, 4'b0010, CNT_W'(1)}) begin
      errors++;
      $display("FAIL single_err_recover: got e=%b x=%b ec=%0d want 0 0010 1", err, expected, err_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, m_exp, 0);
      checks++;
      if ({locked, err, expected, err_cnt, chk_cnt} !== {m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt}) begin
        errors++;
        $display("FAIL single_err_tail%0d: got l=%b e=%b x=%b ec=%0d cc=%0d want l=%b e=%b x=%b ec=%0d cc=%0d",
                 i, locked, err, expected, err_cnt, chk_cnt, m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt);
      end
    end
  endtask

  task automatic test_loss_of_lock();
    logic [3:0] relock [3] = '{4'b0010, 4'b0100, 4'b1001};
    for (int k = 1; k <= 4; k++) begin
      step(1, 4'b0000, 0);
      checks++;
      if ({err, err_cnt, locked} !== {1'b1, CNT_W'(1 + k), (k < 4) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("FAIL loss_zero%0d: got e=%b ec=%0d l=%b want 1 %0d %0d", k, err, err_cnt, locked, 1 + k, k < 4);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1, relock[i], 0);
      checks++;
      if ({locked, err} !== {(i == 2) ? 1'b1 : 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL relock%0d: got l=%b e=%b want %0d 0", i, locked, err, i == 2);
      end
    end
  endtask

  task automatic test_sync_gaps();
    // {valid, word}; the zero word must break the first partial run.
    logic [4:0] pat [9] = '{5'h11, 5'h00, 5'h10, 5'h11, 5'h00, 5'h12, 5'h00, 5'h00, 5'h14};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(pat[i][4], pat[i][3:0], 0);
      checks++;
      if ({locked, err, expected} !== {m_locked, m_err, m_exp} || locked !== (i == 8)) begin
        errors++;
        $display("FAIL gaps_step%0d: got l=%b e=%b x=%b want l=%b e=%b x=%b",
                 i, locked, err, expected, m_locked, m_err, m_exp);
      end
    end
    apply_reset();
    step(1, 4'b0001, 0);
    step(1, 4'b0010, 0);
    step(1, 4'b1111, 0);
    checks++;
    if ({locked, expected} !== {1'b0, 4'b1110}) begin
      errors++;
      $display("FAIL restart_word: got l=%b x=%b want 0 1110", locked, expected);
    end
    step(1, 4'b1110, 0);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL restart_run2: got l=%b want 0", locked);
    end
    step(1, 4'b1100, 0);
    checks++;
    if ({locked, expected, err} !== {1'b1, 4'b1000, 1'b0}) begin
      errors++;
      $display("FAIL restart_lock: got l=%b x=%b e=%b want 1 1000 0", locked, expected, err);
    end
  endtask

  task automatic test_clr_and_async_reset();
    apply_reset();
    step(1, 4'hF, 0); step(1, 4'hE, 0); step(1, 4'hC, 0);
    step(1, ~m_exp, 0); step(1, m_exp, 0); step(1, ~m_exp, 0);
    checks++;
    if ({locked, err_cnt} !== {1'b1, CNT_W'(2)}) begin
      errors++;
      $display("FAIL clr_setup: got l=%b ec=%0d want 1 2", locked, err_cnt);
    end
    step(1, ~m_exp, 1);  // clr together with a counting mismatch
    checks++;
    if ({err_cnt, chk_cnt, locked, err} !== {{CNT_W{1'b0}}, {CNT_W{1'b0}}, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL clr_wins: got ec=%0d cc=%0d l=%b e=%b want 0 0 1 1", err_cnt, chk_cnt, locked, err);
    end
    step(1, ~m_exp, 0);
    checks++;
    if ({err_cnt, chk_cnt, locked, err} !== {m_err_cnt, m_chk_cnt, m_locked, m_err}) begin
      errors++;
      $display("FAIL clr_after: got ec=%0d cc=%0d l=%b e=%b want %0d %0d %b %b",
               err_cnt, chk_cnt, locked, err, m_err_cnt, m_chk_cnt, m_locked, m_err);
    end
    #2;
    rst = 1;
    #1;
    checks++;
    if ({locked, err, err_cnt, chk_cnt, expected} !== {1'b0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}, 4'h0}) begin
      errors++;
      $display("FAIL async_reset: got l=%b e=%b ec=%0d cc=%0d x=%b want all zero",
               locked, err, err_cnt, chk_cnt, expected);
    end
    #2;
    rst = 0;
    model_reset();
  endtask

  task automatic test_saturation();
    apply_reset();
    step(1, 4'hF, 0); step(1, 4'hE, 0); step(1, 4'hC, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, ~m_exp, 0);
      step(1, m_exp, 0);
    end
    checks++;
    if ({err_cnt, chk_cnt, locked} !== {{CNT_W{1'b1}}, {CNT_W{1'b1}}, 1'b1}) begin
      errors++;
      $display("FAIL saturation: got ec=%0d cc=%0d l=%b want %0d %0d 1",
               err_cnt, chk_cnt, locked, (1 << CNT_W) - 1, (1 << CNT_W) - 1);
    end
  endtask

  task automatic test_random();
    bit         v;
    bit         c;
    logic [3:0] d;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 5) != 0);
      c = ($urandom_range(0, 63) == 0);
      if (m_locked) d = seq[m_pos];
      else if (m_prev >= 0) d = seq[(m_prev + 1) % 15];
      else d = seq[$urandom_range(0, 14)];
      case ($urandom_range(0, 15))
        0:       d = 4'h0;
        1, 2:    d = 4'($urandom_range(1, 15));
        default: ;
      endcase
      step(v, d, c);
      checks++;
      if ({locked, err, expected, err_cnt, chk_cnt} !== {m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt}) begin
        errors++;
        $display("FAIL random_step%0d: got l=%b e=%b x=%b ec=%0d cc=%0d want l=%b e=%b x=%b ec=%0d cc=%0d",
                 i, locked, err, expected, err_cnt, chk_cnt, m_locked, m_err, m_exp, m_err_cnt, m_chk_cnt);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_clean_run();
    test_single_error();
    test_loss_of_lock();
    test_sync_gaps();
    test_clr_and_async_reset();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
